// File: rtl/imsic_msi_sched_if.sv
// ----------------------------------------------------------------------------
// imsic_msi_sched_if
// Bundles the requester-side MSI handshake and the outgoing MSI pulse link of
// imsic_msi_sched.
//
// Handshake: a requester holds req_vld[r] high with a stable word in
// req_info[r*W +: W] until req_rdy[r] is seen high. A word transfers on every
// rising clk edge where req_vld[r] & req_rdy[r]. req_rdy is one-hot or zero.
//
// Signals
//   req_vld        requesters -> scheduler   per-requester valid
//   req_info       requesters -> scheduler   packed requester words
//   req_rdy        scheduler  -> requesters  one-hot grant
//   o_msi_info     scheduler  -> CSR gates   MSI word on the link
//   o_msi_info_vld scheduler  -> CSR gates   shaped valid pulse
// ----------------------------------------------------------------------------
interface imsic_msi_sched_if #(
  parameter int NR_REQ         = 4,
  parameter int MSI_INFO_WIDTH = 17
);
  logic [NR_REQ-1:0]                req_vld;
  logic [NR_REQ*MSI_INFO_WIDTH-1:0] req_info;
  logic [NR_REQ-1:0]                req_rdy;
  logic [MSI_INFO_WIDTH-1:0]        o_msi_info;
  logic                             o_msi_info_vld;

  // Requester / link-observer side.
  modport master (
    output req_vld,
    output req_info,
    input  req_rdy,
    input  o_msi_info,
    input  o_msi_info_vld
  );

  // Scheduler side.
  modport slave (
    input  req_vld,
    input  req_info,
    output req_rdy,
    output o_msi_info,
    output o_msi_info_vld
  );
endinterface

// File: rtl/imsic_msi_sched.sv
// ----------------------------------------------------------------------------
// imsic_msi_sched
// Collects MSI writes from NR_REQ requesters with a round-robin arbiter,
// discards words carrying an illegal interrupt identity, buffers the legal
// ones in a small FIFO and serialises them onto the msi_info / msi_info_vld
// pulse link. Each pulse is held high VLD_HIGH_CYC cycles, then low
// VLD_LOW_CYC cycles with the word held, so a slower receiver sees every MSI
// exactly once.
//
// Ports
//   clk          clock
//   rstn         asynchronous active-low reset
//   bus          slave side of imsic_msi_sched_if (handshake + pulse link)
//   o_busy       FIFO non-empty or link FSM not idle
//   o_fifo_cnt   FIFO occupancy
//   o_drop_cnt   saturating count of dropped illegal MSIs
//   o_fsm_state  link FSM state (debug)
// ----------------------------------------------------------------------------
module imsic_msi_sched #(
  parameter int NR_REQ         = 4,
  parameter int MSI_INFO_WIDTH = 17,
  parameter int NR_SRC         = 32,
  parameter int NR_SRC_WIDTH   = $clog2(NR_SRC),
  parameter int FIFO_DEPTH     = 4,
  parameter int VLD_HIGH_CYC   = 4,
  parameter int VLD_LOW_CYC    = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  imsic_msi_sched_if.slave              bus,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic [15:0]                   o_drop_cnt,
  output logic [1:0]                    o_fsm_state
);

  localparam int W       = MSI_INFO_WIDTH;
  localparam int PTR_W   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int CNT_MAX = (VLD_HIGH_CYC > VLD_LOW_CYC) ? VLD_HIGH_CYC : VLD_LOW_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Registers
  state_e                  state_q;
  logic [CNT_W-1:0]        tmr_q;
  logic                    vld_q;
  logic [W-1:0]            info_q;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [W-1:0]            mem_q [FIFO_DEPTH];
  logic [W-1:0]            mem_d [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  // Arbitration / datapath
  int                      scan_idx;
  logic                    grant_vld;
  logic [PTR_W-1:0]        grant_idx;
  logic [NR_REQ-1:0]       grant_oh;
  logic [W-1:0]            grant_info;
  logic [NR_SRC_WIDTH-1:0] setipnum;
  logic                    id_over;
  logic                    id_legal;
  logic                    push;
  logic                    drop;
  logic                    pop;

  // Round-robin search starting at rr_ptr_q. Fullness is judged on the
  // current count only, so a pop in the same cycle never opens req_rdy.
  always_comb begin
    scan_idx  = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (fifo_cnt_q != CW'(FIFO_DEPTH)) begin
      for (int i = 0; i < NR_REQ; i++) begin
        scan_idx = int'(rr_ptr_q) + i;
        if (scan_idx >= NR_REQ) scan_idx = scan_idx - NR_REQ;
        if (!grant_vld && bus.req_vld[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == PTR_W'(NR_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  assign grant_info = bus.req_info[grant_idx*W +: W];
  assign setipnum   = grant_info[NR_SRC_WIDTH-1:0];

  // The upper-range check only exists when NR_SRC leaves setipnum codes unused.
  generate
    if (NR_SRC < (1 << NR_SRC_WIDTH)) begin : g_range_chk
      assign id_over = ({1'b0, setipnum} >= (NR_SRC_WIDTH + 1)'(NR_SRC));
    end else begin : g_no_range_chk
      assign id_over = 1'b0;
    end
  endgenerate

  assign id_legal = (setipnum != '0) && !id_over;
  assign push     = grant_vld && id_legal;
  assign drop     = grant_vld && !id_legal;
  assign pop      = (state_q == ST_IDLE) && (fifo_cnt_q != '0);

  // FIFO next state; pointers wrap naturally since FIFO_DEPTH is a power of 2.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = grant_info;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      mem_q      <= mem_d;
    end
  end

  // Link FSM. o_msi_info only loads on IDLE->HIGH, so the word stays stable
  // through the whole high and low phase for the receiver's falling-edge capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      vld_q   <= 1'b0;
      info_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            info_q  <= mem_q[rd_ptr_q];
            vld_q   <= 1'b1;
            tmr_q   <= CNT_W'(VLD_HIGH_CYC - 1);
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tmr_q == '0) begin
            vld_q   <= 1'b0;
            tmr_q   <= CNT_W'(VLD_LOW_CYC - 1);
            state_q <= ST_LOW;
          end else begin
            tmr_q <= tmr_q - CNT_W'(1);
          end
        end
        ST_LOW: begin
          if (tmr_q == '0) state_q <= ST_IDLE;
          else             tmr_q   <= tmr_q - CNT_W'(1);
        end
        default: begin
          state_q <= ST_IDLE;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_rdy        = grant_oh;
  assign bus.o_msi_info     = info_q;
  assign bus.o_msi_info_vld = vld_q;
  assign o_busy             = (fifo_cnt_q != '0) || (state_q != ST_IDLE);
  assign o_fifo_cnt         = fifo_cnt_q;
  assign o_drop_cnt         = drop_cnt_q;
  assign o_fsm_state        = state_q;

endmodule
